// File: rtl/shift_conv_engine.sv
// shift_conv_engine
//   K x K multiplier-free convolution engine. Every weight is a power-of-two
//   shift plus a sign bit, so each tap costs a shifter and an optional negate.
//   Pixel columns stream in through a valid/ready handshake into a K-column
//   sliding window. Each complete window goes through a registered term stage
//   and a registered sum/post-process stage. A segment FSM sequences one row:
//   it fills the window, runs, then drains the pipeline.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   mode       post-process select, latched on start
//              (bit0: ReLU, bit1: signed saturate)
//   start      single-cycle pulse that begins a segment (IDLE only)
//   row_len    columns in the segment, latched on start, clamped up to K
//   wt_we      weight write strobe (IDLE only)
//   wt_addr    weight index r*K+c; indices >= K*K are dropped
//   wt_data    {sign, shift}
//   in_valid   column valid
//   in_ready   engine accepts a column this cycle
//   in_col     column pixels; row r at [r*DW +: DW]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   convolution result
//   busy       segment in progress (any state but IDLE)
//   done       one-cycle pulse once a segment has fully drained
module shift_conv_engine #(
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int SW    = 3,
  parameter int OW    = 16,
  parameter int ACC_W = DW + 2**SW + $clog2(K*K)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      mode,
  input  logic            start,
  input  logic [7:0]      row_len,
  input  logic            wt_we,
  input  logic [5:0]      wt_addr,
  input  logic [SW:0]     wt_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [K*DW-1:0] in_col,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  state_t     state;
  logic [1:0] mode_q;
  logic [7:0] len_q;
  logic [7:0] col_cnt;
  logic [7:0] col_nxt;
  logic [SW:0] wt [K*K];

  logic [K*DW-1:0]          win_p0 [K];
  logic                     vld_p0;
  logic signed [ACC_W-1:0]  terms_p1 [K*K];
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  sum_p1;

  logic stall;
  logic accept;
  logic issue;
  logic drained;

  // Shift the pixel by the weight's shift field, then apply the sign.
  function automatic logic signed [ACC_W-1:0] shift_term(input logic [DW-1:0] pix,
                                                         input logic [SW:0]   w);
    logic [ACC_W-1:0] mag;
    mag = {{(ACC_W-DW){1'b0}}, pix} << w[SW-1:0];
    return w[SW] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [OW-1:0] sat_signed(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OW-1:0];
    else                  return v[OW-1:0];
  endfunction

  // ReLU first, then either saturate or wrap to OW bits. ReLU followed by
  // signed saturation naturally lands in [0, 2^(OW-1)-1].
  function automatic logic [OW-1:0] post_proc(input logic signed [ACC_W-1:0] s,
                                              input logic [1:0]              m);
    logic signed [ACC_W-1:0] v;
    v = (m[0] && s < 0) ? '0 : s;
    if (m[1]) return sat_signed(v);
    return v[OW-1:0];
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == FILL || state == RUN) && !stall;
  assign accept   = in_valid && in_ready;
  assign col_nxt  = col_cnt + 8'd1;
  // The K-th column and every later one completes a window.
  assign issue    = accept && (col_nxt >= 8'(K));
  assign drained  = !vld_p0 && !vld_p1 && (!out_valid || out_ready);
  assign busy     = (state != IDLE);

  // Segment control and weight storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      col_cnt <= '0;
      done    <= 1'b0;
      for (int i = 0; i < K*K; i++) wt[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wt_we) begin
            for (int i = 0; i < K*K; i++)
              if (wt_addr == 6'(i)) wt[i] <= wt_data;
          end
          if (start) begin
            mode_q  <= mode;
            len_q   <= (row_len < 8'(K)) ? 8'(K) : row_len;
            col_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            col_cnt <= col_nxt;
            if (col_nxt == len_q)     state <= DRAIN;
            else if (col_nxt == 8'(K)) state <= RUN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sum of all taps; ACC_W is wide enough that this never overflows.
  always_comb begin
    sum_p1 = '0;
    for (int i = 0; i < K*K; i++) sum_p1 = sum_p1 + terms_p1[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < K; c++)   win_p0[c]   <= '0;
      for (int i = 0; i < K*K; i++) terms_p1[i] <= '0;
    end else begin
      // ---- p0: sliding window, column 0 oldest ----
      if (accept) begin
        for (int c = 0; c < K-1; c++) win_p0[c] <= win_p0[c+1];
        win_p0[K-1] <= in_col;
      end
      if (!stall) begin
        vld_p0 <= issue;
        // ---- p1: per-tap shifted/negated terms ----
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              terms_p1[r*K+c] <= shift_term(win_p0[c][r*DW +: DW], wt[r*K+c]);
        end
        // ---- p2: summed, post-processed result ----
        out_valid <= vld_p1;
        if (vld_p1) out_data <= post_proc(sum_p1, mode_q);
      end
    end
  end

endmodule

// File: tb/tb_shift_conv_engine.sv
module tb_shift_conv_engine;
  localparam int K  = 3;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int OW = 16;
  localparam longint SMAX = (64'sd1 <<< (OW-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (OW-1));

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      mode = '0;
  logic            start = 1'b0;
  logic [7:0]      row_len = '0;
  logic            wt_we = 1'b0;
  logic [5:0]      wt_addr = '0;
  logic [SW:0]     wt_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [K*DW-1:0] in_col = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [OW-1:0]   out_data;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shift_conv_engine #(.K(K), .DW(DW), .SW(SW), .OW(OW)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .start(start), .row_len(row_len),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // Reference state
  int              m_sign  [K*K];
  int              m_shift [K*K];
  logic [K*DW-1:0] cols [256];
  logic [OW-1:0]   exp_q [$];

  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b1;
  bit  rand_bp = 1'b0;
  int  stall_start = -100;
  int  done_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Signed sum of sign * pixel * 2^shift over the window ending at column j.
  function automatic longint win_sum(input int j);
    longint s = 0;
    longint t;
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++) begin
        t = longint'(cols[j-K+1+c][r*DW +: DW]) * (longint'(1) <<< m_shift[r*K+c]);
        s += (m_sign[r*K+c] != 0) ? -t : t;
      end
    return s;
  endfunction

  function automatic logic [OW-1:0] post(input longint s, input logic [1:0] m);
    longint v = s;
    if (m[0] && v < 0) v = 0;
    if (m[1]) begin
      if (v > SMAX) v = SMAX;
      if (v < SMIN) v = SMIN;
    end
    return OW'(v);
  endfunction

  task automatic monitor_loop();
    bit            held_v = 1'b0;
    logic [OW-1:0] held_d = '0;
    logic [OW-1:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!reset_n || !mon_en) begin
        held_v = 1'b0;
      end else begin
        if (out_valid && held_v) chk("hold_stable", out_data, held_d);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", out_data, -1);
          else begin
            e = exp_q.pop_front();
            chk("result", out_data, e);
          end
          held_v = 1'b0;
        end else if (out_valid) begin
          chk("in_ready_stall", in_ready, 0);
          held_v = 1'b1;
          held_d = out_data;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  endtask

  task automatic bp_loop();
    forever begin
      @(posedge clk);
      #1;
      out_ready = !(cyc >= stall_start && cyc < stall_start + 5) &&
                  (!rand_bp || $urandom_range(0, 3) != 0);
    end
  endtask

  task automatic set_wt(input int idx, input int sg, input int sh);
    wt_we   = 1'b1;
    wt_addr = 6'(idx);
    wt_data = {sg[0], SW'(sh)};
    @(posedge clk); #1;
    wt_we = 1'b0;
    if (idx < K*K) begin
      m_sign[idx]  = sg;
      m_shift[idx] = sh;
    end
  endtask

  task automatic set_all(input int sg, input int sh);
    for (int i = 0; i < K*K; i++) set_wt(i, sg, sh);
  endtask

  task automatic set_random_wts();
    for (int i = 0; i < K*K; i++) set_wt(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
  endtask

  // Present one column and hold it until the engine takes it.
  task automatic feed_col(input logic [K*DW-1:0] c, output bit ok);
    bit rdy = 1'b0;
    in_valid = 1'b1;
    in_col   = c;
    for (int n = 0; n < 200 && !rdy; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      wt_we = 1'b0;
      start = 1'b0;
    end
    in_valid = 1'b0;
    ok = rdy;
  endtask

  task automatic run_seg(input logic [1:0] m, input int len, input int fill,
                         input longint exp_const, input int stall_at,
                         input bit poke, input bit reuse, input bit gaps, input bit lat);
    int eff;
    bit ok;
    bit got;
    eff = (len < K) ? K : len;
    if (!reuse)
      for (int i = 0; i < eff; i++)
        for (int r = 0; r < K; r++)
          cols[i][r*DW +: DW] = (fill >= 0) ? DW'(fill) : DW'($urandom);
    for (int j = K-1; j < eff; j++)
      exp_q.push_back((exp_const >= 0) ? OW'(exp_const) : post(win_sum(j), m));

    mode = m; row_len = 8'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < eff; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      if (stall_at == i) stall_start = cyc + 1;
      if (poke && i == K) begin
        wt_we   = 1'b1;
        wt_addr = 6'd4;
        wt_data = {~m_sign[4][0], SW'(7 - m_shift[4])};
        start   = 1'b1;
        mode    = ~m;
        row_len = 8'd4;
      end
      feed_col(cols[i], ok);
      if (!ok) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end

    if (lat) begin
      @(posedge clk); @(negedge clk);
      chk("latency_edge1", out_valid, 0);
      @(posedge clk); @(negedge clk);
      chk("latency_edge2", out_valid, 1);
    end

    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", got, 1);
    chk("results_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    int d0;
    for (int i = 0; i < K*K; i++) begin
      m_sign[i] = 0;
      m_shift[i] = 0;
    end
    fork
      monitor_loop();
      bp_loop();
    join_none

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset weights, all-ones pixels: single result of 9 with 2-cycle latency
    run_seg(2'b00, 3, 1, 9, -1, 0, 0, 0, 1);

    // Centre tap +<<7, others -1; indices >= K*K must be dropped
    set_all(1, 0);
    set_wt(4, 0, 7);
    set_wt(9, 0, 5);
    set_wt(63, 0, 5);
    run_seg(2'b00, 3, 255, 30600, -1, 0, 0, 0, 0);
    run_seg(2'b10, 3, 255, 30600, -1, 0, 0, 0, 0);

    // All taps <<7: wrap and saturate
    set_all(0, 7);
    run_seg(2'b00, 3, 255, 31616, -1, 0, 0, 0, 0);
    run_seg(2'b10, 3, 255, 32767, -1, 0, 0, 0, 0);
    run_seg(2'b11, 3, 255, 32767, -1, 0, 0, 0, 0);

    // All taps -1, pixels 10: negative sum
    set_all(1, 0);
    run_seg(2'b00, 3, 10, 'hFFA6, -1, 0, 0, 0, 0);
    run_seg(2'b01, 3, 10, 0, -1, 0, 0, 0, 0);
    run_seg(2'b11, 3, 10, 0, -1, 0, 0, 0, 0);

    // Back-pressure: out_ready low for 5 cycles in the middle of a 6-column row
    set_random_wts();
    run_seg(2'($urandom_range(0, 3)), 6, -1, -1, 3, 0, 0, 0, 0);

    // Weight write and start while busy are ignored; rerun with same data
    set_random_wts();
    run_seg(2'b00, 7, -1, -1, -1, 1, 0, 0, 0);
    run_seg(2'b00, 7, -1, -1, -1, 0, 1, 0, 0);

    // Random segments with random back-pressure, input gaps and short rows
    rand_bp = 1'b1;
    for (int s = 0; s < 8; s++) begin
      set_random_wts();
      run_seg(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)), -1, -1, -1, 0, 0, 1, 0);
    end
    rand_bp = 1'b0;

    // Reset in the middle of RUN
    set_random_wts();
    mon_en = 1'b0;
    mode = 2'b00; row_len = 8'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) feed_col(K*DW'($urandom), ok);
    chk("busy_before_abort", busy, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    for (int i = 0; i < K*K; i++) begin
      m_sign[i] = 0;
      m_shift[i] = 0;
    end
    mon_en = 1'b1;
    run_seg(2'b10, 5, -1, -1, -1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_conv_engine.md
Name: shift_conv_engine

Overview:
- Parametrised K x K multiplier-free convolution engine. Each weight is a power-of-two shift with a sign bit.
- Pixel columns stream in through a valid/ready handshake and are held in an internal K-column sliding window. The window is reduced through a registered shift/negate stage and a registered adder tree.
- Adds a run-time weight-load port, a segment state machine, output back-pressure and selectable output post-processing.
- Sits between the row line-buffers and the feature-map writer in the accelerator datapath.

Parameters:
- K, 3: kernel rows and columns; legal range 2..7.
- DW, 8: unsigned pixel width.
- SW, 3: weight shift-field width; shift range is 0..2^SW-1.
- OW, 16: output width.
- ACC_W, DW+2^SW+$clog2(K*K): signed internal accumulator width, including the sign bit.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  2  output post-process select; sampled on start
- start  in  1  single-cycle pulse; begins one segment; honoured only in IDLE
- row_len  in  8  columns in the segment; sampled on start; values below K are clamped to K
- wt_we  in  1  weight write strobe; honoured only in IDLE
- wt_addr  in  6  weight index r*K+c; indices >= K*K are ignored
- wt_data  in  SW+1  {sign, shift}
- in_valid  in  1  pixel column valid
- in_ready  out  1  engine can accept a column
- in_col  in  K*DW  column pixels; row r occupies bits [r*DW +: DW]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OW  convolution result
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse when a segment fully drains

Behaviour:
- Reset state: FSM in IDLE; all weights {0,0}, i.e. +1; window and pipeline registers 0; all outputs 0.
- Reset asserted mid-segment aborts the segment immediately; no done pulse is produced.
- Term arithmetic: term(r,c) = pix(r,c) << shift(r,c), zero-extended to ACC_W. When sign=1 the term is two's-complement negated. Sum = signed sum of all K*K terms, with no internal overflow.
- Column 0 of the window is the oldest column. An accepted column shifts in at column K-1.
- mode 00: out_data = Sum[OW-1:0], wrapping.
- mode 01: ReLU, then low OW bits.
- mode 10: signed saturate to [-2^(OW-1), 2^(OW-1)-1].
- mode 11: ReLU, then saturate to [0, 2^(OW-1)-1].
- State IDLE: in_ready=0; weight writes take effect on the next edge. On start: latch mode and row_len, clear the column counter, go to FILL. A start outside IDLE is ignored.
- State FILL: accept columns until K have been accepted, then go to RUN. The window does not produce results.
- State RUN: each accepted column, including the K-th, issues one window into the pipeline. After row_len columns have been accepted, go to DRAIN.
- State DRAIN: in_ready=0. Once both pipeline stages are empty and the output register has been taken, go to IDLE and pulse done for one cycle.
- Results per segment: exactly row_len-K+1.
- Pipeline: stage 1 registers the K*K terms; stage 2 registers the mode-processed sum into out_data/out_valid. The column that completes a window is accepted at edge t, and out_valid rises after edge t+2.
- Stall: stall = out_valid && !out_ready.
  - While stalled, the pipeline and window freeze and in_ready=0.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - Full throughput is one result per cycle when out_ready is held high.
- Simultaneous events:
  - Acceptance and output in the same cycle is allowed.
  - wt_we in the same cycle as start: the write is honoured and the segment starts using the updated weight.

Test Plan:
- Weights at reset value, mode 00, row_len=3, three columns of all 1s: exactly one result, 9, appearing 2 cycles after the 3rd column is accepted; done follows.
- Weight (1,1)={0,7}, all others sign=1 shift=0, pixels all 255, mode 00: Sum=32640-2040=30600, so out_data=30600. The same stimulus with mode 10 also gives 30600.
- All weights {0,7}, pixels 255, K=3: Sum=293760. Check mode 00 gives 293760 mod 65536=31616, mode 10 gives 32767, mode 11 gives 32767.
- All weights sign=1 shift=0, pixels 10: mode 00 gives 0xFFA6 (-90); mode 01 and mode 11 give 0.
- row_len=6 with out_ready held low for 5 cycles mid-stream:
  - exactly 4 results, in order, with no loss or duplication;
  - out_data stable throughout the stall;
  - in_ready low while stalled.
- Error and reset handling:
  - wt_we and start issued while busy are ignored, confirmed by re-running with the old expected results.
  - Asserting reset_n low mid-RUN gives out_valid=0, busy=0, all weights back to +1, and no done pulse.
